// File: rtl/pow2_scale_pkg.sv
// pow2_scale_pkg: shared types and helpers for pow2_scale_up.
//   state_t      - FSM state encoding (IDLE, SHIFT, DONE)
//   shamt_width  - width needed to hold a shift amount 0..max_shift
//   SAT_COUNT_W  - width of the optional saturation event counter
package pow2_scale_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam int SAT_COUNT_W = 16;

   function automatic int shamt_width(input int max_shift);
      return $clog2(max_shift + 1);
   endfunction

endpackage

// File: rtl/pow2_scale_up.sv
// pow2_scale_up: multiplies din by 2^shamt, one bit-shift per clock,
// saturating to all-ones if any 1 bit is shifted out of the MSB.
// Optional macro POW2_SCALE_SAT_COUNT_EN adds a saturation event counter.
// Ports:
//   clk, reset        - clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready - input handshake; in_ready high only in IDLE
//   din, shamt        - value to scale, shift amount (clamped to MAX_SHIFT)
//   out_valid/out_ready - output handshake; out_valid high only in DONE
//   dout, sat         - scaled result (all-ones when saturated), saturate flag
//   sat_count         - (macro only) count of saturated results delivered
module pow2_scale_up
   import pow2_scale_pkg::*;
#(
   parameter int W         = 32,
   parameter int MAX_SHIFT = 3,
   parameter int SHAMT_W   = shamt_width(MAX_SHIFT)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       din,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W-1:0]       dout,
   output logic               sat
`ifdef POW2_SCALE_SAT_COUNT_EN
   ,
   output logic [SAT_COUNT_W-1:0] sat_count
`endif
);

   localparam logic [SHAMT_W-1:0] MAX_CNT = SHAMT_W'(MAX_SHIFT);

   state_t             state;
   logic [W-1:0]       acc;
   logic [SHAMT_W-1:0] cnt;
   logic               satf;

   logic [SHAMT_W-1:0] shamt_c;
   logic [W-1:0]       acc_nxt;
   logic               sat_nxt;

   always_comb begin
      shamt_c = (shamt > MAX_CNT) ? MAX_CNT : shamt;
      acc_nxt = {acc[W-2:0], 1'b0};
      // sticky: any 1 leaving the MSB means the product does not fit
      sat_nxt = satf | acc[W-1];
   end

   // Handshake outputs decode directly from state, so no input-to-output path.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         satf  <= 1'b0;
         dout  <= '0;
         sat   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc  <= din;
                  satf <= 1'b0;
                  cnt  <= shamt_c;
                  if (shamt_c != '0) begin
                     state <= SHIFT;
                  end else begin
                     dout  <= din;
                     sat   <= 1'b0;
                     state <= DONE;
                  end
               end
            end
            SHIFT: begin
               acc  <= acc_nxt;
               satf <= sat_nxt;
               cnt  <= cnt - 1'b1;
               // result registers are loaded on the final shift so DONE
               // presents them without an extra cycle
               if (cnt == SHAMT_W'(1)) begin
                  dout  <= sat_nxt ? '1 : acc_nxt;
                  sat   <= sat_nxt;
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef POW2_SCALE_SAT_COUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sat_count <= '0;
      end else if ((state == DONE) && out_ready && sat && (sat_count != '1)) begin
         sat_count <= sat_count + 1'b1;
      end
   end
`else
   // no saturation counter in this build
`endif

endmodule

// File: tb/tb_pow2_scale_up.sv
module tb_pow2_scale_up;

   localparam int W = 32;
   localparam int MAX_SHIFT = 3;
   localparam int SHAMT_W = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [W-1:0]       din;
   logic [SHAMT_W-1:0] shamt;
   logic               out_valid;
   logic               out_ready;
   logic [W-1:0]       dout;
   logic               sat;
`ifdef POW2_SCALE_SAT_COUNT_EN
   logic [15:0]        sat_count;
   int                 exp_sat_count = 0;
`endif

   int total = 0;
   int bad = 0;

   pow2_scale_up #(.W(W), .MAX_SHIFT(MAX_SHIFT)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .din(din),
      .shamt(shamt),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .dout(dout),
      .sat(sat)
`ifdef POW2_SCALE_SAT_COUNT_EN
      ,
      .sat_count(sat_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]       din;
      logic [SHAMT_W-1:0] shamt;
      logic [W-1:0]       exp_dout;
      logic               exp_sat;
      int                 exp_lat;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Launch one job, wait for out_valid, hold out_ready low for 'hold' cycles,
   // then complete the handshake. Returns latency in edges from accept (inclusive).
   task automatic run_job(input logic [W-1:0] d, input logic [SHAMT_W-1:0] s, input int hold,
                          input logic poke_busy, output int lat,
                          output logic [W-1:0] rdout, output logic rsat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      check("in_ready_before_job", {31'b0, in_ready}, 1);
      din = d; shamt = s; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 50) begin
         check("in_ready_busy", {31'b0, in_ready}, 0);
         @(posedge clk); #1; lat++;
      end
      check("out_valid_seen", {31'b0, out_valid}, 1);
      rdout = dout; rsat = sat;
      for (int i = 0; i < hold; i++) begin
         if (poke_busy) begin
            in_valid = 1'b1; din = 99; shamt = 2'd1;
         end
         @(posedge clk); #1;
         check("hold_valid", {31'b0, out_valid}, 1);
         check("hold_dout", dout, rdout);
         check("hold_in_ready", {31'b0, in_ready}, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("after_hs_out_valid", {31'b0, out_valid}, 0);
      check("after_hs_in_ready", {31'b0, in_ready}, 1);
   endtask

   initial begin
      int lat;
      logic [W-1:0] rd;
      logic rs;

      vecs[0] = '{32'd5,          2'd3, 32'd40,         1'b0, 4};
      vecs[1] = '{32'h1FFF_FFFF,  2'd3, 32'hFFFF_FFF8,  1'b0, 4};
      vecs[2] = '{32'h2000_0000,  2'd3, 32'hFFFF_FFFF,  1'b1, 4};
      vecs[3] = '{32'h8000_0000,  2'd1, 32'hFFFF_FFFF,  1'b1, 2};
      vecs[4] = '{32'hDEAD_BEEF,  2'd0, 32'hDEAD_BEEF,  1'b0, 1};
      vecs[5] = '{32'd0,          2'd3, 32'd0,          1'b0, 4};
      vecs[6] = '{32'h4000_0000,  2'd1, 32'h8000_0000,  1'b0, 2};
      vecs[7] = '{32'h4000_0000,  2'd2, 32'hFFFF_FFFF,  1'b1, 3};
      vecs[8] = '{32'd3,          2'd2, 32'd12,         1'b0, 3};

      reset = 1'b1; in_valid = 1'b0; din = '0; shamt = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'b0, in_ready}, 1);
      check("rst_out_valid", {31'b0, out_valid}, 0);
      check("rst_dout", dout, 0);
      check("rst_sat", {31'b0, sat}, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         run_job(vecs[i].din, vecs[i].shamt, 0, 1'b0, lat, rd, rs);
         check($sformatf("v%0d_dout", i), rd, vecs[i].exp_dout);
         check($sformatf("v%0d_sat", i), {31'b0, rs}, {31'b0, vecs[i].exp_sat});
         check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
`ifdef POW2_SCALE_SAT_COUNT_EN
         if (vecs[i].exp_sat) exp_sat_count++;
         check($sformatf("v%0d_sat_count", i), {16'b0, sat_count}, exp_sat_count);
`endif
      end

      // backpressure with a second request while busy
      run_job(32'd7, 2'd2, 5, 1'b1, lat, rd, rs);
      check("bp_dout", rd, 32'd28);
      check("bp_sat", {31'b0, rs}, 0);
      check("bp_latency", lat, 3);
      // the poked request must not have been taken: still idle one cycle on
      @(posedge clk); #1;
      check("bp_no_extra_job", {31'b0, out_valid}, 0);
      check("bp_idle", {31'b0, in_ready}, 1);

      // back-to-back throughput: shamt=1 job accepted every cnt+2 = 3 cycles
      din = 32'd9; shamt = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;             // accept
      @(posedge clk); #1;             // enters DONE
      check("tp_valid", {31'b0, out_valid}, 1);
      check("tp_dout", dout, 32'd18);
      @(posedge clk); #1;             // handshake
      check("tp_ready_again", {31'b0, in_ready}, 1);
      in_valid = 1'b0; out_ready = 1'b0;

      // reset in the middle of a shamt=3 job; dout is nonzero from the prior job
      din = 32'h2000_0000; shamt = 2'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("midrst_out_valid", {31'b0, out_valid}, 0);
      check("midrst_dout", dout, 0);
      check("midrst_sat", {31'b0, sat}, 0);
      check("midrst_in_ready", {31'b0, in_ready}, 1);
`ifdef POW2_SCALE_SAT_COUNT_EN
      check("midrst_sat_count", {16'b0, sat_count}, 0);
      exp_sat_count = 0;
`endif
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check("post_rst_no_output", {31'b0, out_valid}, 0);
      end
      run_job(32'd1, 2'd1, 0, 1'b0, lat, rd, rs);
      check("post_rst_dout", rd, 32'd2);
      check("post_rst_sat", {31'b0, rs}, 0);
      check("post_rst_latency", lat, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pow2_scale_up.md
Name: pow2_scale_up

Overview:
- Inverse of the team's rounding power-of-two divider: multiplies a stored quotient back up by 2^shamt.
- shamt is selectable at run time; the result saturates to all-ones on overflow.
- Iterative, one bit-shift per clock, with valid/ready handshakes on both sides.
- Sits on the reconstruction path after the rounding-division stage, feeding full-scale consumers.

Parameters:
- W, 32, data width of din and dout.
- MAX_SHIFT, 3, largest legal shift; matches the divider's DIV_LOG2.
- SHAMT_W, $clog2(MAX_SHIFT+1), width of shamt (derived; do not override).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  din/shamt valid.
- in_ready  output  1  block can accept; high only in IDLE.
- din  input  W  unsigned value to scale.
- shamt  input  SHAMT_W  shift amount; values > MAX_SHIFT clamp to MAX_SHIFT.
- out_valid  output  1  dout/sat valid.
- out_ready  input  1  consumer accepts.
- dout  output  W  din*2^shamt, or all-ones if saturated.
- sat  output  1  result saturated.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- States: IDLE, SHIFT, DONE.
- Reset, asynchronous and immediate, including mid-operation:
  - state=IDLE; in_ready=1; out_valid=0; dout=0; sat=0.
  - Shift register, remaining-count and sat flag are cleared.
  - An in-flight job is discarded with no output.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load acc=din, cnt=min(shamt,MAX_SHIFT), satf=0.
  - Go to SHIFT if cnt>0, else to DONE.
- SHIFT, each cycle:
  - If acc[W-1]==1, set satf=1 (sticky).
  - Then acc=acc<<1 (zero fill) and cnt=cnt-1.
  - Go to DONE when cnt reaches 0.
- DONE:
  - out_valid=1; dout = satf ? all-ones : acc; sat=satf.
  - dout and sat are held stable while out_ready=0.
  - On out_valid&&out_ready, return to IDLE.
  - No new input is accepted in the same cycle.
- Latency: out_valid rises exactly cnt+1 cycles after the accepting edge, i.e. 1 cycle for shamt=0 and 4 cycles for shamt=3.
- Throughput: one job per cnt+2 cycles minimum.
- Outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- in_valid while busy is ignored; the source must hold data until in_ready.
- Overflow rule: saturation iff any 1 bit is shifted out of bit W-1. Exact products that fit W bits never saturate.
- din=0 never saturates, at any shamt.

Optional Feature:
- Macro: POW2_SCALE_SAT_COUNT_EN.
- Defined:
  - Adds output sat_count [15:0], reset to 0.
  - Increments by 1 on each output handshake with sat=1.
  - Saturates at 0xFFFF (no wrap).
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pow2_scale_pkg holds:
  - state enum type (IDLE, SHIFT, DONE);
  - function shamt_width(max_shift) returning $clog2(max_shift+1);
  - localparam SAT_COUNT_W=16.
- No sub-module; FSM, shifter and counter are small enough to live in one module.

Test Plan (W=32, MAX_SHIFT=3):
- Basic scaling: din=5, shamt=3, out_ready=1 -> dout=40, sat=0, out_valid exactly 4 cycles after accept.
- Largest non-saturating input: din=0x1FFF_FFFF, shamt=3 -> dout=0xFFFF_FFF8, sat=0.
- Overflow:
  - din=0x2000_0000, shamt=3 -> dout=0xFFFF_FFFF, sat=1.
  - din=0x8000_0000, shamt=1 -> dout=0xFFFF_FFFF, sat=1.
  - With POW2_SCALE_SAT_COUNT_EN, sat_count=2 after both.
- Zero shift: din=0xDEAD_BEEF, shamt=0 -> dout=0xDEAD_BEEF, sat=0, 1-cycle latency, in_ready low until output handshake.
- Backpressure: din=7, shamt=2, out_ready low 5 cycles -> dout=28 held stable; in_ready=0 throughout; a second in_valid is ignored until after the handshake.
- Reset mid-job: assert reset during the SHIFT cycle of a shamt=3 job -> out_valid=0, dout=0, sat=0 immediately. After release: in_ready=1 and a fresh job din=1, shamt=1 returns 2.
